// File: rtl/forward_unit_if.sv
// forward_unit_if: operand-forwarding bus between register-read, the later pipeline stages and execute.
interface forward_unit_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] R2res1;
  logic [DATA_W-1:0] R3res1;
  logic [ADDR_W-1:0] R2_2;
  logic [ADDR_W-1:0] R3_2;
  logic [1:0]        ExtndSel1;
  logic [1:0]        RMuxSel1;
  logic              VF2;
  logic [ADDR_W-1:0] DestR_3;
  logic [DATA_W-1:0] Res;
  logic              VF3;
  logic [ADDR_W-1:0] DestR_4;
  logic [DATA_W-1:0] Res1;
  logic [DATA_W-1:0] R2res2;
  logic [DATA_W-1:0] R3res2;
  logic [1:0]        FwdSel2;
  logic [1:0]        FwdSel3;
  logic [1:0]        FwdEvt;
  modport slave (
    input  R2res1, R3res1, R2_2, R3_2, ExtndSel1, RMuxSel1,
           VF2, DestR_3, Res, VF3, DestR_4, Res1,
    output R2res2, R3res2, FwdSel2, FwdSel3, FwdEvt
  );
  modport master (
    output R2res1, R3res1, R2_2, R3_2, ExtndSel1, RMuxSel1,
           VF2, DestR_3, Res, VF3, DestR_4, Res1,
    input  R2res2, R3res2, FwdSel2, FwdSel3, FwdEvt
  );
endinterface

// File: rtl/forward_unit.sv
// forward_unit: combinational bypass of R2/R3 operands from stage 3 (priority) or stage 4,
// plus a registered per-cycle forwarding-event status.
module forward_unit (
  input logic           clk,
  input logic           rst_n,
  forward_unit_if.slave f
);
  logic       hit3_r2, hit4_r2, hit3_r3, hit4_r3;
  logic [1:0] fwd_evt_d, fwd_evt_q;
  always_comb begin
    hit3_r2   = !f.ExtndSel1[1] && f.DestR_3 == f.R2_2 && f.VF2 == f.RMuxSel1[1];
    hit4_r2   = !f.ExtndSel1[1] && f.DestR_4 == f.R2_2 && f.VF3 == f.RMuxSel1[1];
    hit3_r3   = !f.ExtndSel1[0] && f.DestR_3 == f.R3_2 && f.VF2 == f.RMuxSel1[0];
    hit4_r3   = !f.ExtndSel1[0] && f.DestR_4 == f.R3_2 && f.VF3 == f.RMuxSel1[0];
    // stage 3 holds the newest value, so it wins when both stages match
    f.R2res2  = hit3_r2 ? f.Res : hit4_r2 ? f.Res1 : f.R2res1;
    f.R3res2  = hit3_r3 ? f.Res : hit4_r3 ? f.Res1 : f.R3res1;
    f.FwdSel2 = hit3_r2 ? 2'b01 : hit4_r2 ? 2'b10 : 2'b00;
    f.FwdSel3 = hit3_r3 ? 2'b01 : hit4_r3 ? 2'b10 : 2'b00;
    fwd_evt_d = {hit3_r2 | hit4_r2, hit3_r3 | hit4_r3};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fwd_evt_q <= 2'b00;
    else        fwd_evt_q <= fwd_evt_d;
  assign f.FwdEvt = fwd_evt_q;
endmodule

// File: tb/tb_forward_unit.sv
// tb_forward_unit: directed + random stimulus; expectations queued at drive time, checked by a negedge monitor.
module tb_forward_unit;
  localparam int DW = 128;
  localparam int AW = 4;
  typedef struct {
    logic [DW-1:0] r2, r3, res, res1;
    logic [AW-1:0] a2, a3, d3, d4;
    logic [1:0]    ext, rmux;
    logic          vf2, vf3;
  } vec_t;
  typedef struct {
    logic [DW-1:0] r2, r3;
    logic [1:0]    sel2, sel3, evt;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  logic [1:0] last_evt;
  forward_unit_if #(.DATA_W(DW), .ADDR_W(AW)) f();
  forward_unit dut (.clk(clk), .rst_n(rst_n), .f(f));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // reference: walk producers newest-first, first matching one supplies the operand
  function automatic exp_t model(input vec_t v);
    exp_t e;
    logic [DW-1:0] val;
    logic [1:0] src;
    logic [AW-1:0] a;
    logic [AW-1:0] dst [2];
    logic vf [2];
    logic [DW-1:0] res [2];
    dst = '{v.d3, v.d4};
    vf  = '{v.vf2, v.vf3};
    res = '{v.res, v.res1};
    e = '{default: '0};
    for (int k = 0; k < 2; k++) begin
      a   = k == 0 ? v.a2 : v.a3;
      val = k == 0 ? v.r2 : v.r3;
      src = 2'd0;
      for (int s = 0; s < 2; s++)
        if (src == 2'd0 && !v.ext[1-k] && dst[s] == a && vf[s] == v.rmux[1-k]) begin
          src = 2'(s + 1);
          val = res[s];
        end
      if (k == 0) begin e.r2 = val; e.sel2 = src; end
      else        begin e.r3 = val; e.sel3 = src; end
    end
    return e;
  endfunction
  task automatic drive(input vec_t v);
    f.R2res1 = v.r2; f.R3res1 = v.r3; f.Res = v.res; f.Res1 = v.res1;
    f.R2_2 = v.a2; f.R3_2 = v.a3; f.DestR_3 = v.d3; f.DestR_4 = v.d4;
    f.ExtndSel1 = v.ext; f.RMuxSel1 = v.rmux; f.VF2 = v.vf2; f.VF3 = v.vf3;
  endtask
  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    drive(v);
    e = model(v);
    e.evt = last_evt;
    q.push_back(e);
    last_evt = {|e.sel2, |e.sel3};
  endtask
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("R2res2", f.R2res2, e.r2);
      chk("R3res2", f.R3res2, e.r3);
      chk("FwdSel2", DW'(f.FwdSel2), DW'(e.sel2));
      chk("FwdSel3", DW'(f.FwdSel3), DW'(e.sel3));
      chk("FwdEvt", DW'(f.FwdEvt), DW'(e.evt));
    end
  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    vec_t b, v;
    b = '{r2: DW'('h10), r3: DW'('h64), res: DW'('h15), res1: DW'('h16),
          a2: 4'd5, a3: 4'd6, d3: 4'd5, d4: 4'd6, ext: 2'b11, rmux: 2'b00, vf2: 1'b0, vf3: 1'b0};
    drive(b);
    last_evt = 2'b00;
    #3;
    chk("reset_FwdEvt", DW'(f.FwdEvt), DW'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    apply(b);
    v = b; v.ext = 2'b01; apply(v);
    v.ext = 2'b00; apply(v);
    v.d3 = 4'd8; apply(v);
    v.d4 = 4'd0; apply(v);
    v = b; v.ext = 2'b00; v.rmux = 2'b11; apply(v);
    v.vf2 = 1'b1; v.vf3 = 1'b1; apply(v);
    v = b; v.ext = 2'b00; v.d4 = 4'd5; apply(v);
    @(posedge clk);
    #2;
    chk("pre_rst_FwdEvt", DW'(f.FwdEvt), DW'(last_evt));
    rst_n = 0;
    #1;
    chk("async_rst_FwdEvt", DW'(f.FwdEvt), DW'(0));
    chk("rst_R2res2", f.R2res2, DW'('h15));
    chk("rst_R3res2", f.R3res2, DW'('h64));
    #1;
    rst_n = 1;
    for (int i = 0; i < 300; i++) begin
      v.r2 = rnd_data(); v.r3 = rnd_data(); v.res = rnd_data(); v.res1 = rnd_data();
      v.a2 = AW'($urandom_range(0, 3)); v.a3 = AW'($urandom_range(0, 3));
      v.d3 = AW'($urandom_range(0, 3)); v.d4 = AW'($urandom_range(0, 3));
      v.ext = 2'($urandom); v.rmux = 2'($urandom);
      v.vf2 = 1'($urandom); v.vf3 = 1'($urandom);
      apply(v);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, 0 required", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
